video_frame_analyzer: RTL and testbench

// - Receive end of the pixel stream built by the video source: RGB plus hsync/vsync/enable at pixel rate.
// - Recovers frame geometry: active width/height, line and frame totals.
// - Computes a CRC-32 over every active pixel.
// - Publishes per-frame statistics with a one-cycle valid strobe, for bench self-checking and on-chip overlay health monitoring.

---
 rtl/video_pkg.sv | 16 +
 rtl/video_crc32.sv | 38 +++
 rtl/video_frame_analyzer.sv | 208 ++++++++++++++++++++
 tb/tb_video_frame_analyzer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared constants and types for the video receive-side frame analyzer.
// CRC-32 parameters, the pixel word type and the measurement FSM states.
package video_pkg;

    localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

    localparam int COLSPC_DEFAULT = 10;
    typedef logic [3*COLSPC_DEFAULT-1:0] pixel_t;

    typedef enum logic {
        SEEK    = 1'b0,
        MEASURE = 1'b1
    } video_state_t;

endpackage

// File: rtl/video_crc32.sv
// CRC-32 accumulator (poly 0x04C11DB7, MSB-first, non-reflected, no final XOR).
// Folds one DW-bit word per enabled cycle; init re-seeds and may fold in the same cycle.
module video_crc32
    import video_pkg::*;
#(
    parameter int          DW   = 30,
    parameter logic [31:0] INIT = CRC32_INIT
) (
    input  logic          video_clk_pix,
    input  logic          video_rst_n,
    input  logic          init,
    input  logic          en,
    input  logic [DW-1:0] data,
    output logic [31:0]   crc
);

    logic [31:0] seed;
    logic [31:0] crc_nxt;

    always_comb begin
        seed    = init ? INIT : crc;
        crc_nxt = seed;
        for (int i = DW - 1; i >= 0; i--) begin
            crc_nxt = {crc_nxt[30:0], 1'b0} ^ ((crc_nxt[31] ^ data[i]) ? CRC32_POLY : 32'h0);
        end
    end

    always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
        if (!video_rst_n) begin
            crc <= INIT;
        end else if (en) begin
            crc <= crc_nxt;
        end else if (init) begin
            crc <= INIT;
        end
    end

endmodule

// File: rtl/video_frame_analyzer.sv
// Receive-side analyzer: recovers frame geometry from hsync/vsync/enable, CRCs the
// active pixels and publishes per-frame statistics with a one-cycle stat_valid strobe.
module video_frame_analyzer
    import video_pkg::*;
#(
    parameter int          COLSPC   = 10,
    parameter int          CNTW     = 16,
    parameter logic [31:0] CRC_INIT = CRC32_INIT
) (
    input  logic              video_clk_pix,
    input  logic              video_rst_n,
    input  logic              video_enable,
    input  logic              hsync,
    input  logic              vsync,
    input  logic [COLSPC-1:0] red,
    input  logic [COLSPC-1:0] green,
    input  logic [COLSPC-1:0] blue,
    output logic              stat_valid,
    output logic [CNTW-1:0]   active_width,
    output logic [CNTW-1:0]   active_height,
    output logic [CNTW-1:0]   h_total,
    output logic [CNTW-1:0]   v_total,
    output logic [31:0]       frame_crc,
    output logic [CNTW-1:0]   frame_count,
    output logic              locked
);

    localparam int              PW      = 3 * COLSPC;
    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic          s_enable;
    logic          s_hsync;
    logic          s_vsync;
    logic [PW-1:0] s_pixel;
    logic          s_hsync_q;
    logic          s_vsync_q;

    logic          vrise;
    logic          hrise;
    logic          d_enable;
    logic [PW-1:0] d_pixel;

    always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
        if (!video_rst_n) begin
            s_enable <= 1'b0;
            s_hsync  <= 1'b0;
            s_vsync  <= 1'b0;
            s_pixel  <= '0;
        end else begin
            s_enable <= video_enable;
            s_hsync  <= hsync;
            s_vsync  <= vsync;
            s_pixel  <= {red, green, blue};
        end
    end

    // Edges are registered so data and sync stay aligned one stage behind the input regs.
    always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
        if (!video_rst_n) begin
            s_hsync_q <= 1'b0;
            s_vsync_q <= 1'b0;
            vrise     <= 1'b0;
            hrise     <= 1'b0;
            d_enable  <= 1'b0;
            d_pixel   <= '0;
        end else begin
            s_hsync_q <= s_hsync;
            s_vsync_q <= s_vsync;
            vrise     <= s_vsync & ~s_vsync_q;
            hrise     <= s_hsync & ~s_hsync_q;
            d_enable  <= s_enable;
            d_pixel   <= s_pixel;
        end
    end

    video_state_t state;
    video_state_t state_nxt;
    logic         report;

    always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
        if (!video_rst_n) begin
            state <= SEEK;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        report    = 1'b0;
        case (state)
            SEEK: begin
                if (vrise) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                report = vrise;
            end
            default: begin
                state_nxt = SEEK;
            end
        endcase
    end

    logic [CNTW-1:0] cyc_cnt;
    logic [CNTW-1:0] htot_r;
    logic [CNTW-1:0] line_en_cnt;
    logic [CNTW-1:0] width_r;
    logic [CNTW-1:0] height_cnt;
    logic [CNTW-1:0] vtot_cnt;
    logic [31:0]     crc_val;

    // Values the open line contributes when it is closed this cycle, by hrise or vrise.
    logic            line_has_en;
    logic [CNTW-1:0] close_width;
    logic [CNTW-1:0] close_height;
    logic [CNTW-1:0] close_htotal;

    assign line_has_en  = (line_en_cnt != '0);
    assign close_width  = line_has_en ? line_en_cnt : width_r;
    assign close_height = line_has_en ? sat_inc(height_cnt) : height_cnt;
    assign close_htotal = hrise ? cyc_cnt : htot_r;

    // A coincident hrise starts line 1 of the new frame, so vrise handling takes priority.
    always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
        if (!video_rst_n) begin
            cyc_cnt     <= '0;
            htot_r      <= '0;
            line_en_cnt <= '0;
            width_r     <= '0;
            height_cnt  <= '0;
            vtot_cnt    <= '0;
        end else begin
            if (hrise) begin
                cyc_cnt <= CNT_ONE;
                htot_r  <= cyc_cnt;
            end else begin
                cyc_cnt <= sat_inc(cyc_cnt);
            end

            if (vrise) begin
                line_en_cnt <= d_enable ? CNT_ONE : '0;
                width_r     <= '0;
                height_cnt  <= '0;
                vtot_cnt    <= hrise ? CNT_ONE : '0;
            end else if (hrise) begin
                line_en_cnt <= d_enable ? CNT_ONE : '0;
                width_r     <= close_width;
                height_cnt  <= close_height;
                vtot_cnt    <= sat_inc(vtot_cnt);
            end else if (d_enable) begin
                line_en_cnt <= sat_inc(line_en_cnt);
            end
        end
    end

    video_crc32 #(
        .DW   (PW),
        .INIT (CRC_INIT)
    ) u_crc (
        .video_clk_pix (video_clk_pix),
        .video_rst_n   (video_rst_n),
        .init          (vrise),
        .en            (d_enable),
        .data          (d_pixel),
        .crc           (crc_val)
    );

    logic have_prev;

    // locked compares against the report registers, which still hold the previous frame.
    always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
        if (!video_rst_n) begin
            stat_valid    <= 1'b0;
            active_width  <= '0;
            active_height <= '0;
            h_total       <= '0;
            v_total       <= '0;
            frame_crc     <= '0;
            frame_count   <= '0;
            locked        <= 1'b0;
            have_prev     <= 1'b0;
        end else begin
            stat_valid <= report;
            if (report) begin
                active_width  <= close_width;
                active_height <= close_height;
                h_total       <= close_htotal;
                v_total       <= vtot_cnt;
                frame_crc     <= crc_val;
                frame_count   <= frame_count + CNT_ONE;
                locked        <= have_prev
                                 && (close_width  == active_width)
                                 && (close_height == active_height)
                                 && (close_htotal == h_total)
                                 && (vtot_cnt     == v_total);
                have_prev     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_video_frame_analyzer.sv
// Self-checking bench for video_frame_analyzer: frames described by geometry are
// streamed in and every stat_valid report is compared with a frame-level reference.
module tb_video_frame_analyzer;

    localparam int          HOFF = 4;
    localparam int          VOFF = 2;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    logic        video_clk_pix = 1'b0;
    logic        video_rst_n   = 1'b0;
    logic        video_enable  = 1'b0;
    logic        hsync         = 1'b0;
    logic        vsync         = 1'b0;
    logic [9:0]  red           = '0;
    logic [9:0]  green         = '0;
    logic [9:0]  blue          = '0;
    logic        stat_valid;
    logic [15:0] active_width;
    logic [15:0] active_height;
    logic [15:0] h_total;
    logic [15:0] v_total;
    logic [31:0] frame_crc;
    logic [15:0] frame_count;
    logic        locked;

    video_frame_analyzer dut (
        .video_clk_pix (video_clk_pix),
        .video_rst_n   (video_rst_n),
        .video_enable  (video_enable),
        .hsync         (hsync),
        .vsync         (vsync),
        .red           (red),
        .green         (green),
        .blue          (blue),
        .stat_valid    (stat_valid),
        .active_width  (active_width),
        .active_height (active_height),
        .h_total       (h_total),
        .v_total       (v_total),
        .frame_crc     (frame_crc),
        .frame_count   (frame_count),
        .locked        (locked)
    );

    always #5 video_clk_pix = ~video_clk_pix;

    typedef struct {
        logic [15:0] w;
        logic [15:0] h;
        logic [15:0] ht;
        logic [15:0] vt;
        logic [15:0] fc;
        logic [31:0] crc;
        logic        lk;
    } report_t;

    int          total_checks = 0;
    int          bad_checks   = 0;
    report_t     exp_q[$];
    report_t     pend;
    report_t     prev;
    report_t     mon_exp;
    bit          have_pend    = 1'b0;
    bit          have_prev    = 1'b0;
    logic [15:0] fcount       = '0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference CRC: the whole frame as one MSB-first bit stream divided by the polynomial.
    function automatic logic [31:0] frameCrc(input logic [29:0] pix[$]);
        logic [31:0] c;
        bit          bits[$];
        c = 32'hFFFF_FFFF;
        foreach (pix[k]) begin
            for (int b = 29; b >= 0; b--) bits.push_back(pix[k][b]);
        end
        foreach (bits[k]) begin
            if (c[31] ^ bits[k]) c = (c << 1) ^ POLY;
            else                 c = c << 1;
        end
        return c;
    endfunction

    task automatic queueReport();
        report_t r;
        r = pend;
        fcount++;
        r.fc = fcount;
        r.lk = have_prev && r.w == prev.w && r.h == prev.h && r.ht == prev.ht && r.vt == prev.vt;
        prev      = r;
        have_prev = 1'b1;
        exp_q.push_back(r);
    endtask

    // Streams one frame: vsync and hsync rise together at line 0; abort_at > 0 cuts it short.
    task automatic applyStimulus(input int ht, input int vt, input int w, input int h,
                                 input int mode, input int abort_at);
        logic [29:0] pix_q[$];
        logic [29:0] p;
        bit          act;
        int          cyc;
        if (have_pend) begin
            queueReport();
            have_pend = 1'b0;
        end
        cyc = 0;
        for (int l = 0; l < vt; l++) begin
            for (int c = 0; c < ht; c++) begin
                if (abort_at > 0 && cyc == abort_at) return;
                @(negedge video_clk_pix);
                act = (l >= VOFF) && (l < VOFF + h) && (c >= HOFF) && (c < HOFF + w);
                p   = (mode == 0) ? 30'h0 : (mode == 1) ? 30'h3FFF_FFFF : 30'($urandom);
                hsync        = (c < 2);
                vsync        = (l == 0) && (c < 4);
                video_enable = act;
                {red, green, blue} = p;
                if (act) pix_q.push_back(p);
                cyc++;
            end
        end
        pend.w    = (w > 0 && h > 0) ? 16'(w) : 16'h0;
        pend.h    = (w > 0 && h > 0) ? 16'(h) : 16'h0;
        pend.ht   = (ht > 65535) ? 16'hFFFF : 16'(ht);
        pend.vt   = 16'(vt);
        pend.crc  = frameCrc(pix_q);
        have_pend = 1'b1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_stat_valid"}, 32'(stat_valid), 32'h0);
        checkOutput({tag, "_width"},      32'(active_width), 32'h0);
        checkOutput({tag, "_height"},     32'(active_height), 32'h0);
        checkOutput({tag, "_h_total"},    32'(h_total), 32'h0);
        checkOutput({tag, "_v_total"},    32'(v_total), 32'h0);
        checkOutput({tag, "_crc"},        frame_crc, 32'h0);
        checkOutput({tag, "_count"},      32'(frame_count), 32'h0);
        checkOutput({tag, "_locked"},     32'(locked), 32'h0);
    endtask

    always @(negedge video_clk_pix) begin
        if (video_rst_n && stat_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_stat_valid", 32'(stat_valid), 32'h0);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("width",       32'(active_width),  32'(mon_exp.w));
                checkOutput("height",      32'(active_height), 32'(mon_exp.h));
                checkOutput("h_total",     32'(h_total),       32'(mon_exp.ht));
                checkOutput("v_total",     32'(v_total),       32'(mon_exp.vt));
                checkOutput("frame_crc",   frame_crc,          mon_exp.crc);
                checkOutput("frame_count", 32'(frame_count),   32'(mon_exp.fc));
                checkOutput("locked",      32'(locked),        32'(mon_exp.lk));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int ht, vt, w, h;
        repeat (3) @(negedge video_clk_pix);
        checkResetState("por");
        @(negedge video_clk_pix);
        video_rst_n = 1'b1;
        repeat (4) @(negedge video_clk_pix);

        repeat (3) applyStimulus(24, 12, 16, 8, 0, 0);

        applyStimulus(24, 12, 1, 1, 0, 0);
        applyStimulus(24, 12, 1, 1, 1, 0);

        repeat (2) applyStimulus(24, 12, 16, 8, 2, 0);
        repeat (3) applyStimulus(24, 12, 15, 8, 2, 0);

        for (int g = 0; g < 4; g++) begin
            ht = $urandom_range(40, 20);
            vt = $urandom_range(14, 6);
            w  = $urandom_range(ht - HOFF, 1);
            h  = $urandom_range(vt - VOFF, 1);
            repeat (2) applyStimulus(ht, vt, w, h, 2, 0);
        end

        applyStimulus(24, 12, 16, 8, 2, 150);
        #2 video_rst_n = 1'b0;
        #1 checkResetState("midrst");
        exp_q.delete();
        have_pend    = 1'b0;
        have_prev    = 1'b0;
        fcount       = '0;
        video_enable = 1'b0;
        hsync        = 1'b0;
        vsync        = 1'b0;
        repeat (3) @(negedge video_clk_pix);
        video_rst_n = 1'b1;
        repeat (3) applyStimulus(24, 12, 16, 8, 2, 0);

        applyStimulus(70000, 1, 0, 0, 0, 0);
        applyStimulus(24, 12, 16, 8, 2, 0);

        applyStimulus(24, 12, 16, 8, 0, 10);
        repeat (6) @(negedge video_clk_pix);
        checkOutput("pending_reports", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
